// File: rtl/iic_pkg.sv
// iic_pkg: shared sequencer state encoding and table-entry field layout.
// RD/RD_WAIT exist only when IIC_VERIFY_EN is defined.
package iic_pkg;
  typedef enum logic [3:0] {
    IDLE, FETCH, LATCH, WR, WR_WAIT, GAP,
`ifdef IIC_VERIFY_EN
    RD, RD_WAIT,
`endif
    NEXT, DONE, ERR
  } state_t;
  typedef logic [23:0] entry_t;
  localparam int ADDR_MSB = 23;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;
endpackage

// File: rtl/iic_cfg_rom.sv
// iic_cfg_rom: configuration table, index -> {reg_addr, wr_data}, one-cycle registered read.
module iic_cfg_rom
  import iic_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] idx,
  output entry_t     data
);
  always_ff @(posedge clk)
    case (idx)
      8'd0:    data <= 24'h0010_18;
      8'd1:    data <= 24'h0011_A5;
      8'd2:    data <= 24'h3008_5C;
      8'd3:    data <= 24'h3017_FF;
      default: data <= 24'h0000_00;
    endcase
endmodule

// File: rtl/iic_cfg_sequencer.sv
// iic_cfg_sequencer: walks a register table and writes each entry over an IIC master,
// with NACK retry, transfer timeout and post-write gap; readback check under IIC_VERIFY_EN.
module iic_cfg_sequencer
  import iic_pkg::*;
#(
  parameter int          CLK_FREQ    = 50_000_000,
  parameter logic [7:0]  REG_NUM     = 8'd32,
  parameter logic [15:0] GAP_CYC     = 16'd50_000,
  parameter int          MAX_RETRY   = 3,
  parameter logic [19:0] TIMEOUT_CYC = 20'd1_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cfg_start,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic [7:0]  tbl_idx,
  input  logic [23:0] tbl_data,
  output logic        bit_ctrl,
  output logic        iic_exe,
  output logic        iic_rw_ctrl,
  output logic [15:0] iic_addr,
  output logic [7:0]  iic_data_in,
  input  logic [7:0]  iic_data_out,
  input  logic        iic_ack,
  input  logic        iic_done
);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int TW = $clog2(int'(TIMEOUT_CYC) + 1);
  localparam int GW = $clog2(int'(GAP_CYC) + 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 20'd1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 16'd1);
  if (CLK_FREQ < 1 || REG_NUM == 8'd0 || GAP_CYC == 16'd0 || MAX_RETRY < 1 || TIMEOUT_CYC < 20'd2) begin : g_bad_param
    $error("iic_cfg_sequencer: parameter out of range");
  end
  state_t state, nxt;
  logic [RW-1:0] retry;
  logic [TW-1:0] tmr;
  logic [GW-1:0] gap;
  logic waiting, tmo, retry_last;
`ifdef IIC_VERIFY_EN
  localparam state_t AFTER_GAP = RD;
  assign waiting = state == WR_WAIT || state == RD_WAIT;
  assign iic_rw_ctrl = state == RD || state == RD_WAIT;
  assign iic_exe = state == WR || state == RD;
`else
  localparam state_t AFTER_GAP = NEXT;
  logic unused;
  assign unused = ^iic_data_out;
  assign waiting = state == WR_WAIT;
  assign iic_rw_ctrl = 1'b0;
  assign iic_exe = state == WR;
`endif
  assign tmo = tmr == TMO_LAST;
  assign retry_last = retry == RETRY_LAST;
  assign cfg_busy = state != IDLE;
  assign bit_ctrl = 1'b1;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = cfg_start ? FETCH : IDLE;
      FETCH:   nxt = LATCH;
      LATCH:   nxt = WR;
      WR:      nxt = WR_WAIT;
      WR_WAIT: nxt = iic_done ? (!iic_ack ? GAP : retry_last ? ERR : WR) : tmo ? ERR : WR_WAIT;
      GAP:     nxt = gap == GAP_LAST ? AFTER_GAP : GAP;
`ifdef IIC_VERIFY_EN
      RD:      nxt = RD_WAIT;
      RD_WAIT: nxt = iic_done ? (iic_ack ? (retry_last ? ERR : RD) : iic_data_out == iic_data_in ? NEXT : ERR)
                              : tmo ? ERR : RD_WAIT;
`endif
      NEXT:    nxt = tbl_idx == REG_NUM - 8'd1 ? DONE : FETCH;
      default: nxt = IDLE;
    endcase
  end
  // The timer reloads to 1 outside the wait states so that expiry lands
  // exactly TIMEOUT_CYC cycles after the iic_exe pulse.
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      state <= IDLE;
      retry <= '0;
      tmr <= '0;
      gap <= '0;
      tbl_idx <= '0;
      iic_addr <= '0;
      iic_data_in <= '0;
      cfg_done <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state <= nxt;
      tmr <= waiting ? tmr + 1'b1 : TW'(1);
      gap <= state == GAP ? gap + 1'b1 : '0;
      if (waiting && iic_done) retry <= iic_ack ? retry + 1'b1 : '0;
      if (state == IDLE && cfg_start) begin
        retry <= '0;
        tbl_idx <= '0;
        cfg_done <= 1'b0;
        cfg_err <= 1'b0;
      end
      if (state == LATCH) begin
        iic_addr <= tbl_data[ADDR_MSB:ADDR_LSB];
        iic_data_in <= tbl_data[DATA_MSB:DATA_LSB];
      end
      if (state == NEXT && nxt == FETCH) tbl_idx <= tbl_idx + 8'd1;
      if (nxt == DONE) cfg_done <= 1'b1;
      if (nxt == ERR) cfg_err <= 1'b1;
    end
endmodule

// File: tb/tb_iic_cfg_sequencer.sv
// tb_iic_cfg_sequencer: directed checks of the sequencer against a behavioural IIC master
// model, with the table served by iic_cfg_rom.
module tb_iic_cfg_sequencer;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic cfg_start = 1'b0;
  logic cfg_busy, cfg_done, cfg_err, bit_ctrl, iic_exe, iic_rw_ctrl;
  logic [7:0] tbl_idx, iic_data_in;
  logic [23:0] tbl_data;
  logic [15:0] iic_addr;
  logic [7:0] iic_data_out = 8'd0;
  logic iic_ack = 1'b0;
  logic iic_done = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int n_exe = 0;
  int pend = 0;
  int drv_lat = 3;
  int nack_left = 0;
  logic [15:0] nack_addr = 16'h0;
  logic [15:0] done_addr = 16'h0;
  bit no_done = 1'b0;
  bit rd_bad = 1'b0;
  logic [15:0] exe_addr [16];
  logic [7:0] exe_data [16];
  logic exe_rw [16];
`ifdef IIC_VERIFY_EN
  localparam int PER = 2;
`else
  localparam int PER = 1;
`endif
  always #5 sys_clk = ~sys_clk;
  iic_cfg_rom u_rom (.clk(sys_clk), .idx(tbl_idx), .data(tbl_data));
  iic_cfg_sequencer #(
    .CLK_FREQ(50_000_000), .REG_NUM(8'd3), .GAP_CYC(16'd4), .MAX_RETRY(3), .TIMEOUT_CYC(20'd100)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_start(cfg_start), .cfg_busy(cfg_busy),
    .cfg_done(cfg_done), .cfg_err(cfg_err), .tbl_idx(tbl_idx), .tbl_data(tbl_data),
    .bit_ctrl(bit_ctrl), .iic_exe(iic_exe), .iic_rw_ctrl(iic_rw_ctrl), .iic_addr(iic_addr),
    .iic_data_in(iic_data_in), .iic_data_out(iic_data_out), .iic_ack(iic_ack), .iic_done(iic_done)
  );
  // IIC master model: logs each iic_exe pulse and answers drv_lat cycles later.
  always @(negedge sys_clk) begin
    iic_done = 1'b0;
    iic_ack = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        iic_done = 1'b1;
        done_addr = iic_addr;
        iic_data_out = rd_bad ? 8'd23 : iic_data_in;
        if (nack_left > 0 && iic_addr == nack_addr) begin
          iic_ack = 1'b1;
          nack_left--;
        end
      end
    end
    if (iic_exe) begin
      if (n_exe < 16) begin
        exe_addr[n_exe] = iic_addr;
        exe_data[n_exe] = iic_data_in;
        exe_rw[n_exe] = iic_rw_ctrl;
      end
      n_exe++;
      if (!no_done) pend = drv_lat;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic start_cfg();
    n_exe = 0;
    cfg_start = 1'b1;
    @(negedge sys_clk);
    cfg_start = 1'b0;
  endtask
  task automatic wait_idle(input int budget);
    int c = 0;
    while (cfg_busy && c < budget) begin
      @(negedge sys_clk);
      c++;
    end
    chk("idle_within_budget", 32'(c < budget), 32'd1);
  endtask
  task automatic wait_exe(input int budget);
    int c = 0;
    while (!iic_exe && c < budget) begin
      @(negedge sys_clk);
      c++;
    end
    chk("exe_within_budget", 32'(iic_exe), 32'd1);
  endtask
  function automatic int addr_count(input logic [15:0] a);
    int k = 0;
    for (int i = 0; i < n_exe && i < 16; i++) if (exe_addr[i] == a) k++;
    return k;
  endfunction
  initial begin
    int c;
    int n_before;
    repeat (3) @(negedge sys_clk);
    chk("rst_busy", 32'(cfg_busy), 32'd0);
    chk("rst_done", 32'(cfg_done), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);
    chk("rst_exe", 32'(iic_exe), 32'd0);
    chk("rst_idx", 32'(tbl_idx), 32'd0);
    chk("rst_addr_data", {8'd0, iic_addr, iic_data_in}, 32'd0);
    chk("rst_rw", 32'(iic_rw_ctrl), 32'd0);
    chk("bit_ctrl", 32'(bit_ctrl), 32'd1);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk("idle_no_exe", 32'(n_exe), 32'd0);
    // Plain run over three entries, every transfer ACKed.
    start_cfg();
    chk("busy_after_start", 32'(cfg_busy), 32'd1);
    wait_idle(400);
    chk("ok_pulses", 32'(n_exe), 32'(3 * PER));
    chk("ok_e0", {exe_addr[0], exe_data[0]}, 32'h0010_18);
    chk("ok_e1", {exe_addr[PER], exe_data[PER]}, 32'h0011_A5);
    chk("ok_e2", {exe_addr[2 * PER], exe_data[2 * PER]}, 32'h3008_5C);
    chk("ok_first_is_write", 32'(exe_rw[0]), 32'd0);
    chk("ok_last_rw", 32'(exe_rw[3 * PER - 1]), 32'(PER - 1));
    chk("ok_done", 32'(cfg_done), 32'd1);
    chk("ok_err", 32'(cfg_err), 32'd0);
    chk("ok_idx", 32'(tbl_idx), 32'd2);
    chk("ok_addr_held_to_done", 32'(done_addr), 32'h3008);
    // Entry 1 NACKs twice then ACKs.
    nack_addr = 16'h0011;
    nack_left = 2;
    start_cfg();
    chk("retry_done_cleared", 32'(cfg_done), 32'd0);
    wait_idle(400);
    chk("retry_pulses", 32'(n_exe), 32'(5 + 3 * (PER - 1)));
    chk("retry_e1_pulses", 32'(addr_count(16'h0011)), 32'(3 + PER - 1));
    chk("retry_done", 32'(cfg_done), 32'd1);
    chk("retry_err", 32'(cfg_err), 32'd0);
    // Entry 0 never ACKs.
    nack_addr = 16'h0010;
    nack_left = 1000;
    start_cfg();
    wait_idle(400);
    nack_left = 0;
    chk("nack_pulses", 32'(n_exe), 32'd3);
    chk("nack_err", 32'(cfg_err), 32'd1);
    chk("nack_done", 32'(cfg_done), 32'd0);
    chk("nack_idx", 32'(tbl_idx), 32'd0);
    chk("nack_busy", 32'(cfg_busy), 32'd0);
    // No iic_done at all: error exactly 100 cycles after the pulse.
    no_done = 1'b1;
    start_cfg();
    wait_exe(20);
    c = 0;
    do begin
      @(negedge sys_clk);
      c++;
    end while (!cfg_err && c < 300);
    chk("tmo_cycles", 32'(c), 32'd100);
    chk("tmo_done", 32'(cfg_done), 32'd0);
    chk("tmo_pulses", 32'(n_exe), 32'd1);
    no_done = 1'b0;
    wait_idle(20);
    // Reset during WR_WAIT, the master's iic_done arrives after release.
    drv_lat = 8;
    start_cfg();
    wait_exe(20);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b1;
    #1;
    chk("arst_busy", 32'(cfg_busy), 32'd0);
    chk("arst_state", {8'd0, iic_addr, iic_data_in}, 32'd0);
    chk("arst_flags", {cfg_done, cfg_err, iic_exe, iic_rw_ctrl}, 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    n_before = n_exe;
    repeat (12) @(negedge sys_clk);
    chk("late_done_no_exe", 32'(n_exe), 32'(n_before));
    chk("late_done_idle", {tbl_idx, 7'd0, cfg_busy, 7'd0, cfg_done, 7'd0, cfg_err}, 32'd0);
    drv_lat = 3;
`ifdef IIC_VERIFY_EN
    // Readback returns 23 for a written 24.
    rd_bad = 1'b1;
    start_cfg();
    wait_idle(400);
    rd_bad = 1'b0;
    chk("vfy_err", 32'(cfg_err), 32'd1);
    chk("vfy_pulses", 32'(n_exe), 32'd2);
    chk("vfy_read", {exe_addr[1], 15'd0, exe_rw[1]}, {16'h0010, 16'd1});
    chk("vfy_idx", 32'(tbl_idx), 32'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
